// File: rtl/axilite_port_arbiter_pkg.sv
// rtl/axilite_port_arbiter_pkg.sv - shared types and helpers for the AXI-lite port arbiter
package axilite_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_e;

  localparam int WE_W = 4;

  // Round-robin successor; n need not be a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axilite_port_arbiter_rr_priority_picker.sv
// rtl/axilite_port_arbiter_rr_priority_picker.sv - first set request at or after ptr, wrapping
module axilite_port_arbiter_rr_priority_picker
  import axilite_port_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int best_off;
  int off;

  // Distance from ptr, modulo N, ranks each requester; the smallest wins.
  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    best_off = N;
    off      = 0;
    for (int j = 0; j < N; j++) begin
      off = (j + N - int'(ptr_i)) % N;
      if (req_i[j] && (off < best_off)) begin
        best_off = off;
        found_o  = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/axilite_port_arbiter.sv
// rtl/axilite_port_arbiter.sv - round-robin sharing of one AXI-lite master port
// Grant is held until completion or abandon, then one forced idle cycle on mst_valid_o.
module axilite_port_arbiter
  import axilite_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i,
  input  logic [NUM_REQ*WE_W-1:0]    req_we_i,
  output logic [DATA_W-1:0]          req_rdata_o,
  output logic                       mst_valid_o,
  input  logic                       mst_ready_i,
  output logic [ADDR_W-1:0]          mst_addr_o,
  output logic [DATA_W-1:0]          mst_wdata_o,
  output logic [WE_W-1:0]            mst_we_o,
  input  logic [DATA_W-1:0]          mst_rdata_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       busy_o
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          gnt_valid;

  axilite_port_arbiter_rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign gnt_valid = req_valid_i[grant_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Completion and abandon both release the port and advance fairness.
        if (!gnt_valid || mst_ready_i) begin
          state_d  = ARB_GAP;
          rr_ptr_d = IW'(rr_next(int'(grant_q), NUM_REQ));
        end
      end
      ARB_GAP:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mst_valid_o = 1'b0;
    req_ready_o = '0;
    busy_o      = 1'b0;
    if (state_q == ARB_BUSY) begin
      busy_o               = 1'b1;
      mst_valid_o          = gnt_valid;
      req_ready_o[grant_q] = gnt_valid & mst_ready_i;
    end
  end

  // Request payload follows the grant in every state so the master bus never glitches.
  assign mst_addr_o  = req_addr_i[int'(grant_q)*ADDR_W +: ADDR_W];
  assign mst_wdata_o = req_wdata_i[int'(grant_q)*DATA_W +: DATA_W];
  assign mst_we_o    = req_we_i[int'(grant_q)*WE_W +: WE_W];
  assign req_rdata_o = mst_rdata_i;
  assign grant_o     = grant_q;

endmodule

// File: tb/tb_axilite_port_arbiter.sv
// tb/tb_axilite_port_arbiter.sv - randomized scoreboard bench for axilite_port_arbiter
module tb_axilite_port_arbiter;

  localparam int NR = 3;
  localparam int GW = $clog2(NR);

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*32-1:0]  req_addr;
  logic [NR*32-1:0]  req_wdata;
  logic [NR*4-1:0]   req_we;
  logic [31:0]       req_rdata;
  logic              mst_valid;
  logic              mst_ready;
  logic [31:0]       mst_addr;
  logic [31:0]       mst_wdata;
  logic [3:0]        mst_we;
  logic [31:0]       mst_rdata;
  logic [GW-1:0]     grant;
  logic              busy;

  logic              v  [NR];
  logic [31:0]       a  [NR];
  logic [31:0]       wd [NR];
  logic [3:0]        we [NR];
  bit                stop_req;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] rdata;
  } comp_t;

  typedef struct {
    logic        valid;
    logic        busy;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } cyc_t;

  comp_t comp_q  [$];
  cyc_t  cyc_q   [$];
  int    grant_q [$];

  int n_cmp;
  int n_bad;
  int comps_seen;

  axilite_port_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (32),
    .DATA_W  (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_we_i    (req_we),
    .req_rdata_o (req_rdata),
    .mst_valid_o (mst_valid),
    .mst_ready_i (mst_ready),
    .mst_addr_o  (mst_addr),
    .mst_wdata_o (mst_wdata),
    .mst_we_o    (mst_we),
    .mst_rdata_i (mst_rdata),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  always_comb begin
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_we    = '0;
    for (int k = 0; k < NR; k++) begin
      req_valid[k]          = v[k];
      req_addr[k*32 +: 32]  = a[k];
      req_wdata[k*32 +: 32] = wd[k];
      req_we[k*4 +: 4]      = we[k];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Master: answers a pending request with random latency; sometimes pulses ready while idle.
  initial begin
    mst_ready = 1'b0;
    mst_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mst_valid) mst_ready = ($urandom_range(0, 2) == 0);
      else           mst_ready = ($urandom_range(0, 7) == 0);
      mst_rdata = $urandom;
    end
  end

  // Reference model: one owner at a time, one dead cycle after release, rr search by modulo.
  initial begin
    int   owner;
    int   last;
    int   ptr;
    bit   gap;
    cyc_t c;
    comp_t e;
    owner = -1; last = 0; ptr = 0; gap = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        owner = -1; last = 0; ptr = 0; gap = 0;
        comp_q.delete(); cyc_q.delete(); grant_q.delete();
      end else begin
        c.busy  = (owner >= 0);
        c.valid = (owner >= 0) ? v[owner] : 1'b0;
        c.addr  = a[last];
        c.wdata = wd[last];
        c.we    = we[last];
        cyc_q.push_back(c);
        if (owner >= 0) begin
          if (v[owner] && mst_ready) begin
            e.idx = owner; e.addr = a[owner]; e.wdata = wd[owner];
            e.we = we[owner]; e.rdata = mst_rdata;
            comp_q.push_back(e);
          end
          if (!v[owner] || mst_ready) begin
            ptr   = (owner + 1) % NR;
            owner = -1;
            gap   = 1;
          end
        end else if (gap) begin
          gap = 0;
        end else begin
          for (int i = 0; i < NR; i++) begin
            if (owner < 0 && v[(ptr + i) % NR]) begin
              owner = (ptr + i) % NR;
              last  = owner;
              grant_q.push_back(owner);
            end
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a cycle, a new grant or a completion.
  initial begin
    bit    prev_busy;
    cyc_t  c;
    comp_t e;
    int    g;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_busy = 1'b0;
        continue;
      end
      if (cyc_q.size() == 0) chk("cyc_q_avail", cyc_q.size(), 1);
      else begin
        c = cyc_q.pop_front();
        chk("mst_valid", mst_valid, c.valid);
        chk("busy", busy, c.busy);
        chk("mst_addr_hold", mst_addr, c.addr);
        chk("mst_wdata_hold", mst_wdata, c.wdata);
        chk("mst_we_hold", mst_we, c.we);
      end
      if (busy && !prev_busy) begin
        if (grant_q.size() == 0) chk("grant_q_avail", grant_q.size(), 1);
        else begin
          g = grant_q.pop_front();
          chk("grant", grant, g);
        end
      end
      if (req_ready != '0) begin
        if (comp_q.size() == 0) chk("comp_q_avail", comp_q.size(), 1);
        else begin
          e = comp_q.pop_front();
          chk("ready_vec", req_ready, NR'(1) << e.idx);
          chk("rdata", req_rdata, e.rdata);
          chk("cmp_addr", mst_addr, e.addr);
          chk("cmp_wdata", mst_wdata, e.wdata);
          chk("cmp_we", mst_we, e.we);
          comps_seen++;
        end
      end
      prev_busy = busy;
    end
  end

  task automatic requester(input int k);
    int idle;
    int ab;
    int cnt;
    bit done;
    bit prev_ab;
    prev_ab = 1'b0;
    while (!stop_req) begin
      idle = $urandom_range(0, 3);
      if (prev_ab && idle == 0) idle = 1;
      repeat (idle) begin
        @(posedge clk);
        #1;
      end
      v[k]  = 1'b1;
      a[k]  = $urandom;
      wd[k] = $urandom;
      we[k] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      ab    = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      cnt   = 0;
      done  = 1'b0;
      prev_ab = 1'b0;
      while (!done) begin
        @(negedge clk);
        cnt++;
        if (req_ready[k]) done = 1'b1;
        else if ((ab != 0 && cnt >= ab) || cnt > 400) begin
          done = 1'b1;
          prev_ab = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      v[k] = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; comps_seen = 0; stop_req = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < NR; k++) begin
      v[k] = 1'b0; a[k] = 32'h1000 * (k + 1); wd[k] = $urandom; we[k] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mst_valid", mst_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    rst_n = 1'b1;

    // Grant req1 alone, then pull reset while its request is on the master port.
    v[1] = 1'b1; a[1] = 32'h20; we[1] = 4'h0;
    for (int i = 0; i < 20 && !mst_valid; i++) begin
      @(posedge clk);
      #3;
    end
    chk("wait_valid", mst_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_mst_valid", mst_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v[0] = 1'b1; a[0] = 32'h10; wd[0] = 32'h11223344; we[0] = 4'hF;
    for (int i = 0; i < 20 && !busy; i++) begin
      @(posedge clk);
      #3;
    end
    chk("post_rst_busy", busy, 1);
    chk("post_rst_grant", grant, 0);
    @(posedge clk);
    #1;
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    for (int k = 0; k < NR; k++) begin
      fork
        automatic int kk = k;
        requester(kk);
      join_none
    end
    repeat (3000) @(posedge clk);
    stop_req = 1'b1;
    repeat (600) @(posedge clk);
    @(negedge clk);
    #2;
    chk("grant_q_drained", grant_q.size(), 0);
    chk("comp_q_drained", comp_q.size(), 0);
    chk("progress", comps_seen >= 100, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axilite_port_arbiter.md
Name: axilite_port_arbiter

Overview:
- Shares one AXI-lite master port (valid/ready/addr/wdata/we/rdata request interface) between NUM_REQ core-side requesters, e.g. instruction fetch and load/store unit.
- Round-robin arbitration; a grant is locked until the transaction completes.
- Guarantees one idle cycle on the master-side valid between transactions, so the master's per-transaction handshake tracking clears before the next request.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, `RISCV_ADDR_WIDTH (32), address width
- DATA_W, `RISCV_WORD_WIDTH (32), data width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester completion (1-cycle pulse)
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
- req_wdata_i  in  NUM_REQ*DATA_W  packed write data
- req_we_i  in  NUM_REQ*4  packed byte write enables; 0 means read
- req_rdata_o  out  DATA_W  read data, broadcast; qualified by req_ready_o
- mst_valid_o  out  1  to master valid_i
- mst_ready_i  in  1  from master ready_o
- mst_addr_o  out  ADDR_W  to master addr_i
- mst_wdata_o  out  DATA_W  to master wdata_i
- mst_we_o  out  4  to master we_i
- mst_rdata_i  in  DATA_W  from master rdata_o
- grant_o  out  $clog2(NUM_REQ)  current/last granted index (debug)
- busy_o  out  1  high in BUSY

Behaviour:
- Reset (async, rst_n low): state=IDLE, grant=0, rr_ptr=0, mst_valid_o=0, req_ready_o=0, busy_o=0. Reset mid-transaction abandons it; no completion is reported.
- States: IDLE, BUSY, GAP.
- IDLE → BUSY:
  - If any req_valid_i bit is set, pick the first set bit at or after rr_ptr (wrapping modulo NUM_REQ).
  - Register grant; next cycle is BUSY.
  - Arbitration latency is 1 cycle: request in cycle 0 gives mst_valid_o=1 in cycle 1.
- BUSY:
  - mst_valid_o = req_valid_i[grant].
  - mst_addr_o/mst_wdata_o/mst_we_o are a combinational mux of the granted slice.
  - req_ready_o[grant] = mst_ready_i. All other ready bits are 0.
  - req_rdata_o = mst_rdata_i, combinational.
- BUSY → GAP:
  - When mst_ready_i && req_valid_i[grant], or when req_valid_i[grant]=0 (requester abandoned).
  - On either exit, rr_ptr := (grant+1) mod NUM_REQ.
- GAP: mst_valid_o=0 for exactly one cycle, then IDLE. Arbitration may not occur in GAP.
- Back-to-back throughput: a new grant is at best 3 cycles after the previous ready (GAP, IDLE, BUSY).
- Outside BUSY: mst_addr_o/mst_wdata_o/mst_we_o hold the granted slice (no glitch to zero). mst_valid_o=0.
- Requester contract: addr/wdata/we stay stable while valid is high until ready. The arbiter does not register them.
- Simultaneous requests in IDLE: rr_ptr decides. A new request arriving during BUSY/GAP waits.
- mst_ready_i while not in BUSY is ignored.
- The rr pick uses modulo arithmetic on a log2-width index; NUM_REQ need not be a power of two. The wrap from NUM_REQ-1 goes to 0.

Decomposition:
- Shared defines file (arbiter_defines.v): state encodings ARB_IDLE/ARB_BUSY/ARB_GAP. Width macros come from riscv_defines.v.
- One sub-module, rr_priority_picker: combinational; inputs req vector and rr_ptr; outputs found and index. Reusable for future interrupt/port arbitration.

Test Plan:
- Single read: req0 valid with addr 0x0000_1000, we=0; master model replies ready with rdata 0xCAFEBABE after 3 cycles. Expect mst_valid_o rising 1 cycle after request, req_ready_o=2'b01 for one cycle, req_rdata_o=0xCAFEBABE, mst_valid_o low for exactly 1 cycle after.
- Simultaneous requests after reset: req0 write (addr 0x10, wdata 0x11223344, we=4'hF) and req1 read (addr 0x20). Expect req0 served first, then req1. mst_we_o=4'h0 during the req1 transaction. grant_o goes 0 then 1.
- Fairness: req0 and req1 both held continuously for 6 transactions. Expect grants alternating 0,1,0,1,0,1 and no requester served twice in a row.
- Abandon: req1 granted, then req1 valid drops before mst_ready_i. Expect mst_valid_o=0 next cycle, GAP then IDLE, no req_ready_o pulse, rr_ptr=0.
- Async reset mid-BUSY: assert rst_n=0 asynchronously while mst_valid_o=1. Expect mst_valid_o=0, busy_o=0 immediately; after release the first grant goes to req0.
- NUM_REQ=3 wrap: only req2 requests, then req0 and req2 together. Expect grant 2, then grant 0 (rr_ptr wrapped from 2 to 0).
